// File: rtl/mfp_multi_digit_seven_segment_scanner.sv
// N-digit seven-segment controller: staged static outputs plus a PWM-dimmed,
// time-multiplexed common-segment bus with digit anodes.
module mfp_multi_digit_seven_segment_scanner #(
  parameter int unsigned N_DIGITS         = 8,
  parameter int unsigned CYCLES_PER_DIGIT = 50000,
  parameter bit          ACTIVE_LOW       = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*N_DIGITS-1:0]   digits,
  input  logic [N_DIGITS-1:0]     dp,
  input  logic [N_DIGITS-1:0]     digit_en,
  input  logic                    lz_blank,
  input  logic [3:0]              brightness,
  input  logic                    load,
  output logic [7*N_DIGITS-1:0]   seg_static,
  output logic [N_DIGITS-1:0]     dp_static,
  output logic [6:0]              seg_mux,
  output logic                    dp_mux,
  output logic [N_DIGITS-1:0]     anode,
  output logic                    frame_start
);

  localparam int unsigned CNT_W = $clog2(CYCLES_PER_DIGIT);
  localparam int unsigned LEN_W = CNT_W + 1;
  localparam int unsigned IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam int unsigned STEP  = CYCLES_PER_DIGIT / 16;
  localparam int unsigned DW    = 4 * N_DIGITS;

  localparam logic [CNT_W-1:0] LAST_SLOT = CNT_W'(CYCLES_PER_DIGIT - 1);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(N_DIGITS - 1);

  logic [DW-1:0]       stg_digits, dis_digits;
  logic [N_DIGITS-1:0] stg_dp, stg_en, dis_dp, dis_en;
  logic                stg_lz, dis_lz, pending;
  logic [CNT_W-1:0]    slot_cnt;
  logic [IDX_W-1:0]    idx;
  logic [LEN_W-1:0]    on_len;

  logic                slot_end_c, frame_end_c, window_c;
  logic [6:0]          glyph_c [N_DIGITS];
  logic [N_DIGITS-1:0] dp_c;

  function automatic logic [6:0] hex_glyph(input logic [3:0] nib);
    case (nib)
      4'h0: hex_glyph = 7'h3F;
      4'h1: hex_glyph = 7'h06;
      4'h2: hex_glyph = 7'h5B;
      4'h3: hex_glyph = 7'h4F;
      4'h4: hex_glyph = 7'h66;
      4'h5: hex_glyph = 7'h6D;
      4'h6: hex_glyph = 7'h7D;
      4'h7: hex_glyph = 7'h07;
      4'h8: hex_glyph = 7'h7F;
      4'h9: hex_glyph = 7'h6F;
      4'hA: hex_glyph = 7'h77;
      4'hB: hex_glyph = 7'h7C;
      4'hC: hex_glyph = 7'h39;
      4'hD: hex_glyph = 7'h5E;
      4'hE: hex_glyph = 7'h79;
      default: hex_glyph = 7'h71;
    endcase
  endfunction

  assign slot_end_c  = (slot_cnt == LAST_SLOT);
  assign frame_end_c = slot_end_c && (idx == LAST_IDX);
  assign window_c    = (slot_cnt != '0) && (LEN_W'(slot_cnt) < on_len);

  // Active-high glyphs with enable and leading-zero blanking applied, scanned from the MSD down
  always_comb begin
    logic seen;
    seen    = 1'b0;
    glyph_c = '{default: 7'd0};
    dp_c    = '0;
    for (int i = int'(N_DIGITS) - 1; i >= 0; i--) begin
      seen = seen | (dis_en[i] & ((dis_digits[4*i +: 4] != 4'd0) | dis_dp[i]));
      if (dis_en[i] && !(dis_lz && (i != 0) && !seen)) begin
        glyph_c[i] = hex_glyph(dis_digits[4*i +: 4]);
        dp_c[i]    = dis_dp[i];
      end
    end
  end

  // Scan counters, brightness sampling and stage/display handoff
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_cnt   <= '0;
      idx        <= '0;
      on_len     <= '0;
      stg_digits <= '0;
      stg_dp     <= '0;
      stg_en     <= '0;
      stg_lz     <= 1'b0;
      dis_digits <= '0;
      dis_dp     <= '0;
      dis_en     <= '0;
      dis_lz     <= 1'b0;
      pending    <= 1'b0;
    end else begin
      slot_cnt <= slot_end_c ? '0 : slot_cnt + CNT_W'(1);
      if (slot_end_c) idx <= (idx == LAST_IDX) ? '0 : idx + IDX_W'(1);
      if (slot_cnt == '0) on_len <= LEN_W'((32'(brightness) + 32'd1) * STEP);
      if (frame_end_c && pending) begin
        dis_digits <= stg_digits;
        dis_dp     <= stg_dp;
        dis_en     <= stg_en;
        dis_lz     <= stg_lz;
      end
      // A load in the boundary cycle wins over the clear and waits for the next frame
      if (load) begin
        stg_digits <= digits;
        stg_dp     <= dp;
        stg_en     <= digit_en;
        stg_lz     <= lz_blank;
        pending    <= 1'b1;
      end else if (frame_end_c) begin
        pending    <= 1'b0;
      end
    end
  end

  // Registered pin drivers with polarity applied
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_static  <= {(7*N_DIGITS){ACTIVE_LOW}};
      dp_static   <= {N_DIGITS{ACTIVE_LOW}};
      seg_mux     <= {7{ACTIVE_LOW}};
      dp_mux      <= ACTIVE_LOW;
      anode       <= {N_DIGITS{ACTIVE_LOW}};
      frame_start <= 1'b0;
    end else begin
      for (int i = 0; i < int'(N_DIGITS); i++) begin
        seg_static[7*i +: 7] <= glyph_c[i] ^ {7{ACTIVE_LOW}};
      end
      dp_static   <= dp_c ^ {N_DIGITS{ACTIVE_LOW}};
      anode       <= (window_c ? (N_DIGITS'(1) << idx) : N_DIGITS'(0)) ^ {N_DIGITS{ACTIVE_LOW}};
      seg_mux     <= (window_c ? glyph_c[idx] : 7'd0) ^ {7{ACTIVE_LOW}};
      dp_mux      <= (window_c & dp_c[idx]) ^ ACTIVE_LOW;
      frame_start <= (slot_cnt == '0) && (idx == '0);
    end
  end

endmodule

// File: tb/tb_mfp_multi_digit_seven_segment_scanner.sv
// Bench for the seven-segment scanner: time-based reference model checked every
// cycle, plus directed scenarios with literal expectations.
module tb_mfp_multi_digit_seven_segment_scanner;

  localparam int N     = 4;
  localparam int CPD   = 32;
  localparam int FRAME = N * CPD;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [15:0] digits = '0;
  logic [3:0]  dp = '0, digit_en = '0, brightness = '0;
  logic        lz_blank = 1'b0, load = 1'b0;
  logic [27:0] seg_static;
  logic [3:0]  dp_static, anode;
  logic [6:0]  seg_mux;
  logic        dp_mux, frame_start;

  int tests = 0, fails = 0;
  bit run = 1'b0;

  always #5 clk = ~clk;

  mfp_multi_digit_seven_segment_scanner #(
    .N_DIGITS(N), .CYCLES_PER_DIGIT(CPD), .ACTIVE_LOW(1'b1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .digits(digits), .dp(dp), .digit_en(digit_en),
    .lz_blank(lz_blank), .brightness(brightness), .load(load),
    .seg_static(seg_static), .dp_static(dp_static), .seg_mux(seg_mux),
    .dp_mux(dp_mux), .anode(anode), .frame_start(frame_start)
  );

  logic [6:0] GLY [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                          7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: position in the frame is derived from cycles since reset
  int          t = 0, blat = 0;
  logic [15:0] st_d = '0, ds_d = '0;
  logic [3:0]  st_p = '0, st_e = '0, ds_p = '0, ds_e = '0;
  logic        st_l = 1'b0, ds_l = 1'b0, pend = 1'b0;
  logic [27:0] e_segs = '1;
  logic [3:0]  e_dps = '1, e_an = '1;
  logic [6:0]  e_segm = '1;
  logic        e_dpm = 1'b1, e_fs = 1'b0;

  always @(posedge clk or negedge rst_n) begin : mdl
    int pos, ix, h;
    logic [6:0] g [4];
    logic [3:0] dv;
    if (!rst_n) begin
      t = 0; blat = 0; pend = 1'b0;
      st_d = '0; st_p = '0; st_e = '0; st_l = 1'b0;
      ds_d = '0; ds_p = '0; ds_e = '0; ds_l = 1'b0;
      e_segs = '1; e_dps = '1; e_an = '1; e_segm = '1; e_dpm = 1'b1; e_fs = 1'b0;
    end else begin
      pos = t % CPD;
      ix  = (t / CPD) % N;
      h   = -1;
      for (int j = 0; j < N; j++)
        if (ds_e[j] && (ds_d[4*j +: 4] != 4'd0 || ds_p[j])) h = j;
      for (int j = 0; j < N; j++) begin
        if (!ds_e[j] || (ds_l && j > h && j > 0)) begin
          g[j] = 7'd0; dv[j] = 1'b0;
        end else begin
          g[j] = GLY[ds_d[4*j +: 4]]; dv[j] = ds_p[j];
        end
        e_segs[7*j +: 7] = ~g[j];
      end
      e_dps = ~dv;
      if (pos != 0 && pos < (blat + 1) * (CPD / 16)) begin
        e_an = ~(4'b0001 << ix); e_segm = ~g[ix]; e_dpm = ~dv[ix];
      end else begin
        e_an = 4'hF; e_segm = 7'h7F; e_dpm = 1'b1;
      end
      e_fs = (t % FRAME == 0);
      if (pos == 0) blat = int'(brightness);
      if (t % FRAME == FRAME - 1 && pend) begin
        ds_d = st_d; ds_p = st_p; ds_e = st_e; ds_l = st_l; pend = 1'b0;
      end
      if (load) begin
        st_d = digits; st_p = dp; st_e = digit_en; st_l = lz_blank; pend = 1'b1;
      end
      t++;
    end
  end

  always @(negedge clk) begin
    if (run) begin
      check("anode",       64'(anode),       64'(e_an));
      check("seg_mux",     64'(seg_mux),     64'(e_segm));
      check("dp_mux",      64'(dp_mux),      64'(e_dpm));
      check("frame_start", 64'(frame_start), 64'(e_fs));
      check("seg_static",  64'(seg_static),  64'(e_segs));
      check("dp_static",   64'(dp_static),   64'(e_dps));
    end
  end

  task automatic do_load(input logic [15:0] d, input logic [3:0] p, input logic [3:0] e, input logic l);
    @(negedge clk);
    digits = d; dp = p; digit_en = e; lz_blank = l; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic wait_fs();
    int n;
    n = 0;
    @(negedge clk);
    while (frame_start !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) begin
      tests++; fails++;
      $display("FAIL wait_fs: no frame_start within 300 cycles, got %b expected 1", frame_start);
    end
  endtask

  int act_cnt [4];
  int first_on [4];
  int leak, masked_leak;

  // Observe one full frame starting at the current (frame_start) cycle
  task automatic count_frame();
    leak = 0; masked_leak = 0;
    for (int i = 0; i < N; i++) begin act_cnt[i] = 0; first_on[i] = -1; end
    for (int c = 0; c < FRAME; c++) begin
      for (int i = 0; i < N; i++)
        if (anode[i] == 1'b0) begin
          act_cnt[i]++;
          if (first_on[i] < 0) first_on[i] = c;
        end
      if (anode == 4'hF && seg_mux != 7'h7F) leak++;
      if ((anode[1] == 1'b0 || anode[3] == 1'b0) && seg_mux != 7'h7F) masked_leak++;
      @(negedge clk);
    end
  endtask

  initial begin
    #1 rst_n = 1'b0;
    brightness = 4'd15;
    repeat (3) @(negedge clk);
    check("rst_anode",      64'(anode),       64'h0F);
    check("rst_seg_mux",    64'(seg_mux),     64'h7F);
    check("rst_seg_static", 64'(seg_static),  64'hFFFFFFF);
    rst_n = 1'b1;
    run   = 1'b1;
    @(negedge clk);
    check("fs_after_reset", 64'(frame_start), 64'h1);

    // Staged load appears only at the frame boundary
    do_load(16'h12AF, 4'h0, 4'hF, 1'b0);
    check("stage_hidden", 64'(seg_static), 64'hFFFFFFF);
    wait_fs();
    check("static_12AF", 64'(seg_static), 64'({7'h79, 7'h24, 7'h08, 7'h0E}));

    // Full brightness scan order and frame period
    count_frame();
    for (int i = 0; i < N; i++) begin
      check($sformatf("b15_on_cnt%0d", i), 64'(act_cnt[i]), 64'd31);
      check($sformatf("b15_first%0d", i),  64'(first_on[i]), 64'(32 * i + 1));
    end
    check("b15_leak",  64'(leak),        64'd0);
    check("fs_period", 64'(frame_start), 64'h1);

    // Last of two loads in one frame wins
    do_load(16'h5555, 4'h0, 4'hF, 1'b0);
    repeat (10) @(negedge clk);
    do_load(16'hC0DE, 4'h0, 4'hF, 1'b0);
    wait_fs();
    check("static_C0DE", 64'(seg_static), 64'({7'h46, 7'h40, 7'h21, 7'h06}));

    // Leading-zero blanking
    do_load(16'h0030, 4'h0, 4'hF, 1'b1);
    wait_fs();
    check("lz_0030", 64'(seg_static), 64'({7'h7F, 7'h7F, 7'h30, 7'h40}));
    do_load(16'h0000, 4'h0, 4'hF, 1'b1);
    wait_fs();
    check("lz_0000", 64'(seg_static), 64'({7'h7F, 7'h7F, 7'h7F, 7'h40}));
    do_load(16'h0000, 4'b1000, 4'hF, 1'b1);
    wait_fs();
    check("lz_dp3_seg", 64'(seg_static), 64'({7'h40, 7'h40, 7'h40, 7'h40}));
    check("lz_dp3_dp",  64'(dp_static),  64'h7);

    // PWM levels
    brightness = 4'd3;
    wait_fs();
    count_frame();
    for (int i = 0; i < N; i++) begin
      check($sformatf("b3_on_cnt%0d", i), 64'(act_cnt[i]),  64'd7);
      check($sformatf("b3_first%0d", i),  64'(first_on[i]), 64'(32 * i + 1));
    end
    check("b3_leak", 64'(leak), 64'd0);
    brightness = 4'd0;
    wait_fs();
    count_frame();
    for (int i = 0; i < N; i++)
      check($sformatf("b0_on_cnt%0d", i), 64'(act_cnt[i]), 64'd1);

    // Enable mask: digits 1 and 3 blank but still scanned
    brightness = 4'd15;
    do_load(16'h12AF, 4'h0, 4'b0101, 1'b0);
    wait_fs();
    check("en_static", 64'(seg_static), 64'({7'h7F, 7'h24, 7'h7F, 7'h0E}));
    count_frame();
    for (int i = 0; i < N; i++)
      check($sformatf("en_on_cnt%0d", i), 64'(act_cnt[i]), 64'd31);
    check("en_masked_leak", 64'(masked_leak), 64'd0);

    // Reset mid-slot discards a pending load
    do_load(16'h8888, 4'hF, 4'hF, 1'b0);
    repeat (5) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_anode",      64'(anode),       64'h0F);
    check("midrst_seg_mux",    64'(seg_mux),     64'h7F);
    check("midrst_seg_static", 64'(seg_static),  64'hFFFFFFF);
    check("midrst_fs",         64'(frame_start), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("midrst_fs_release", 64'(frame_start), 64'h1);
    wait_fs();
    wait_fs();
    check("midrst_discard", 64'(seg_static), 64'hFFFFFFF);

    run = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
